// File: rtl/mod2011_pkg.sv
// Shared constants, FSM state type and a reference modular-add helper for the
// modulus-2011 residue accumulator.
package mod2011_pkg;

  localparam int MOD     = 2011;
  localparam int W       = 11;
  localparam int N_TERMS = 84;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // (a + b) mod MOD, valid for a, b < MOD
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    logic [W:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = s - (W+1)'(MOD);
    if (s >= (W+1)'(MOD)) begin
      mod_add = d[W-1:0];
    end else begin
      mod_add = s[W-1:0];
    end
  endfunction

endpackage

// File: rtl/mod2011_add.sv
// Combinational W-bit modular adder: add, compare against MOD, conditional subtract.
// Operands must both be below MOD so one subtract brings the result into range.
module mod2011_add
  import mod2011_pkg::*;
#(
  parameter int MOD_P = MOD,
  parameter int W_P   = W
) (
  input  logic [W_P-1:0] a_i,
  input  logic [W_P-1:0] b_i,
  output logic [W_P-1:0] sum_o
);

  localparam logic [W_P:0] MOD_X = (W_P+1)'(MOD_P);

  logic [W_P:0] sum_s;
  logic [W_P:0] diff_s;

  always_comb begin
    sum_s  = {1'b0, a_i} + {1'b0, b_i};
    diff_s = sum_s - MOD_X;
    if (sum_s >= MOD_X) begin
      sum_o = diff_s[W_P-1:0];
    end else begin
      sum_o = sum_s[W_P-1:0];
    end
  end

endmodule

// File: rtl/mod2011_residue_acc.sv
// Streaming mod-2011 accumulator over one operand frame with a held result handshake.
// Optional input range check: define MOD2011_ACC_RANGE_CHECK_EN.
module mod2011_residue_acc
  import mod2011_pkg::*;
#(
  parameter int MOD_P     = MOD,
  parameter int W_P       = W,
  parameter int N_TERMS_P = N_TERMS,
  parameter int CW        = $clog2(N_TERMS_P + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W_P-1:0] in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_P-1:0] out_residue,
  output logic [CW-1:0]  out_count,
  output logic           err
);

  localparam logic [W_P-1:0] MOD_W    = W_P'(MOD_P);
  localparam logic [CW-1:0]  LAST_CNT = CW'(N_TERMS_P - 1);

  state_e         state_q, state_d;
  logic [W_P-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W_P-1:0] res_q, res_d;
  logic [CW-1:0]  ocnt_q, ocnt_d;
  logic           err_acc_q, err_acc_d;
  logic           err_q, err_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic           oor_s;
  logic [W_P-1:0] term_s;
  logic [W_P-1:0] sum_s;

`ifdef MOD2011_ACC_RANGE_CHECK_EN
  assign oor_s  = (in_data >= MOD_W);
  assign term_s = oor_s ? (in_data - MOD_W) : in_data;
`else
  assign oor_s  = 1'b0;
  assign term_s = in_data;
`endif

  mod2011_add #(
    .MOD_P (MOD_P),
    .W_P   (W_P)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (term_s),
    .sum_o (sum_s)
  );

  // Frame ends on in_last or on the final counted slice, whichever comes first
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    ocnt_d    = ocnt_q;
    err_acc_d = err_acc_q;
    err_d     = err_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d     = sum_s;
          cnt_d     = cnt_q + CW'(1);
          err_acc_d = err_acc_q | oor_s;
          if (in_last || (cnt_q == LAST_CNT)) begin
            res_d   = sum_s;
            ocnt_d  = cnt_q + CW'(1);
            err_d   = err_acc_q | oor_s;
            state_d = HOLD;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d     = '0;
          cnt_d     = '0;
          err_acc_d = 1'b0;
          err_d     = 1'b0;
          state_d   = ACC;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      ocnt_q      <= '0;
      err_acc_q   <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      ocnt_q      <= ocnt_d;
      err_acc_q   <= err_acc_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_residue = res_q;
  assign out_count   = ocnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mod2011_residue_acc.sv
// Scoreboard bench for mod2011_residue_acc: a default instance (84 slices) and a
// short-frame instance (3 slices) share stimulus, selected by sel.
module tb_mod2011_residue_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [10:0] in_data = 11'd0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;

  logic        rdy_a, ovld_a, err_a;
  logic [10:0] res_a;
  logic [6:0]  cnt_a;
  logic        rdy_b, ovld_b, err_b;
  logic [10:0] res_b;
  logic [1:0]  cnt_b;

  logic        in_ready, out_valid, err;
  logic [10:0] out_residue;
  logic [6:0]  out_count;

  typedef struct {
    int res;
    int cnt;
    int er;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int eacc = 0;
  int ecnt = 0;

  always #5 clk = ~clk;

  mod2011_residue_acc u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid & ~sel),
    .in_ready    (rdy_a),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (ovld_a),
    .out_ready   (out_ready),
    .out_residue (res_a),
    .out_count   (cnt_a),
    .err         (err_a)
  );

  mod2011_residue_acc #(.N_TERMS_P(3)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid & sel),
    .in_ready    (rdy_b),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (ovld_b),
    .out_ready   (out_ready),
    .out_residue (res_b),
    .out_count   (cnt_b),
    .err         (err_b)
  );

  assign in_ready    = sel ? rdy_b : rdy_a;
  assign out_valid   = sel ? ovld_b : ovld_a;
  assign out_residue = sel ? res_b : res_a;
  assign out_count   = sel ? {5'd0, cnt_b} : cnt_a;
  assign err         = sel ? err_b : err_a;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Drive one beat, wait for acceptance, update the model and push on frame close
  task automatic send(input int d, input bit last, input bit chk_rdy);
    int guard;
    int nt;
    int dd;
    bit closing;
    guard = 0;
    nt = sel ? 3 : 84;
    in_valid = 1'b1;
    in_data = d[10:0];
    in_last = last;
    if (chk_rdy) check("rdy_b2b", in_ready, 1);
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("rdy_timeout", 0, 1);
    @(posedge clk); #1;
    dd = d;
`ifdef MOD2011_ACC_RANGE_CHECK_EN
    if (dd >= 2011) dd = dd - 2011;
`endif
    eacc = (eacc + dd) % 2011;
    ecnt++;
    closing = last || (ecnt == nt);
    if (closing) begin
`ifdef MOD2011_ACC_RANGE_CHECK_EN
      sb.push_back('{eacc, ecnt, (d >= 2011) ? 1 : 0});
`else
      sb.push_back('{eacc, ecnt, 0});
`endif
      eacc = 0;
      ecnt = 0;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    check("ovld_lat", out_valid, int'(closing));
  endtask

  // Compare each accepted result against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("residue", int'(out_residue), e.res);
        check("count", int'(out_count), e.cnt);
        check("err", int'(err), e.er);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_rdy", in_ready, 1);
    check("rst_ovld", out_valid, 0);
    check("rst_res", int'(out_residue), 0);
    check("rst_cnt", int'(out_count), 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Short-frame instance: closes on count without in_last
    sel = 1'b1;
    send(2010, 1'b0, 1'b0);
    send(2010, 1'b0, 1'b1);
    send(5, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sel = 1'b0;

    // Full 84-beat frame, back-to-back
    for (int i = 0; i < 84; i++) send(2010, 1'b0, i > 0);
    send(1000, 1'b1, 1'b0);
    send(11, 1'b0, 1'b0);
    send(2000, 1'b1, 1'b1);

    // Backpressure with ignored beats during HOLD
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(500, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data = 11'd7;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ovld", out_valid, 1);
      check("bp_res", int'(out_residue), 500);
      check("bp_cnt", int'(out_count), 1);
      check("bp_rdy", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rdy_after", in_ready, 1);
    send(9, 1'b1, 1'b0);

    // Reset mid-frame discards the partial sum
    @(posedge clk); #1;
    send(700, 1'b0, 1'b0);
    send(800, 1'b0, 1'b1);
    rst_n = 1'b0;
    eacc = 0;
    ecnt = 0;
    @(posedge clk); #1;
    check("mid_rst_ovld", out_valid, 0);
    check("mid_rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(100, 1'b1, 1'b0);

    // Out-of-range input
    @(posedge clk); #1;
`ifdef MOD2011_ACC_RANGE_CHECK_EN
    send(2047, 1'b0, 1'b0);
    send(10, 1'b1, 1'b1);
`else
    send(5, 1'b0, 1'b0);
    send(6, 1'b1, 1'b1);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
